// File: rtl/instruction_fetch.sv
// Instruction fetch: PC register, single-outstanding imem read, one-entry instruction buffer toward decode.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirects are presented as a flagged NOP instead of being masked.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetch_misaligned
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        WAIT    = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        r_discard;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_instr_nxt;
    logic [31:0] w_instr_pc_nxt;
    logic        w_discard_nxt;
    logic [31:0] w_redir_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        r_misaligned;
    logic        w_misaligned_nxt;
    logic        w_redir_bad;

    assign w_redir_bad = (redirect_pc[1:0] != 2'b00);
    assign w_redir_pc  = w_redir_bad ? redirect_pc : (redirect_pc & 32'hFFFF_FFFC);
    assign fetch_misaligned = r_misaligned;
`else
    assign w_redir_pc  = redirect_pc & 32'hFFFF_FFFC;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_pc         <= RESET_PC;
            r_instr      <= NOP_WORD;
            r_instr_pc   <= RESET_PC;
            r_discard    <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            r_misaligned <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_instr      <= w_instr_nxt;
            r_instr_pc   <= w_instr_pc_nxt;
            r_discard    <= w_discard_nxt;
`ifdef FETCH_MISALIGN_TRAP_EN
            r_misaligned <= w_misaligned_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_instr_nxt    = r_instr;
        w_instr_pc_nxt = r_instr_pc;
        w_discard_nxt  = r_discard;
`ifdef FETCH_MISALIGN_TRAP_EN
        w_misaligned_nxt = r_misaligned;
`endif

        if (redirect) begin
            // Redirect wins over every other event; anything already in flight is marked for discard.
            w_pc_nxt = w_redir_pc;
            case (r_state)
                REQUEST: begin
                    if (imem_req_ready) begin
                        w_state_nxt   = WAIT;
                        w_discard_nxt = 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        w_state_nxt   = REQUEST;
                        w_discard_nxt = 1'b0;
                    end else begin
                        w_discard_nxt = 1'b1;
                    end
                end
                HOLD: begin
                    w_state_nxt = REQUEST;
                    w_instr_nxt = NOP_WORD;
                end
                default: ;
            endcase
`ifdef FETCH_MISALIGN_TRAP_EN
            w_misaligned_nxt = 1'b0;
            if (w_redir_bad) begin
                w_state_nxt      = HOLD;
                w_instr_nxt      = NOP_WORD;
                w_instr_pc_nxt   = redirect_pc;
                w_misaligned_nxt = 1'b1;
                // Keep dropping any response still owed by memory while the trap NOP is held.
                w_discard_nxt    = ((r_state == REQUEST) && imem_req_ready) ||
                                   ((r_state == WAIT) && !imem_rsp_valid) ||
                                   ((r_state != WAIT) && r_discard && !imem_rsp_valid);
            end
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = REQUEST;
                end
                REQUEST: begin
                    if (imem_req_ready) begin
                        w_state_nxt = WAIT;
                    end
                    if (imem_rsp_valid) begin
                        w_discard_nxt = 1'b0;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (r_discard) begin
                            w_discard_nxt = 1'b0;
                            w_state_nxt   = REQUEST;
                        end else begin
                            w_instr_nxt    = imem_rsp_data;
                            w_instr_pc_nxt = r_pc;
                            w_state_nxt    = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (imem_rsp_valid) begin
                        w_discard_nxt = 1'b0;
                    end
                    if (instr_ready) begin
                        w_instr_nxt = NOP_WORD;
                        w_state_nxt = REQUEST;
`ifdef FETCH_MISALIGN_TRAP_EN
                        if (r_misaligned) begin
                            w_misaligned_nxt = 1'b0;
                        end else begin
                            w_pc_nxt = r_pc + 32'd4;
                        end
`else
                        w_pc_nxt = r_pc + 32'd4;
`endif
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign imem_req_valid = (r_state == REQUEST);
    assign imem_addr      = r_pc;
    assign instr_valid    = (r_state == HOLD);
    assign instr          = r_instr;
    assign opcode         = r_instr[6:0];
    assign instr_pc       = r_instr_pc;
    assign instr_pc_plus4 = r_instr_pc + 32'd4;

endmodule
